// File: rtl/download_mem_arbiter.sv
// download_mem_arbiter: shares one 16-bit memory port between a buffered
// download write stream and a single-outstanding read requester.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   dl_wr, dl_addr, dl_data         download word strobe / address / data
//   dl_busy                         write FIFO full, downloader must hold off
//   dl_overflow                     sticky, a download word was dropped
//   rd_req, rd_addr                 read request (level, held until rd_ack)
//   rd_ack, rd_data                 read completion pulse / held read word
//   mem_req, mem_we, mem_addr,
//   mem_wdata                       registered memory command
//   mem_ready                       memory accepts the command this cycle
//   mem_rvalid, mem_rdata           read data return
module download_mem_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_WIDTH = 25
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dl_wr,
    input  logic [ADDR_WIDTH-1:0] dl_addr,
    input  logic [15:0]           dl_data,
    output logic                  dl_busy,
    output logic                  dl_overflow,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ack,
    output logic [15:0]           rd_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [15:0]           mem_rdata
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StReadWait} state_e;

    logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [15:0]           fifo_data_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [CntW-1:0]       count_q;

    state_e state_q;
    logic   last_write_q;  // type of the last served command: 1 write, 0 read
    logic   settle_q;      // first IDLE cycle after a command, no decision taken

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic pick_write;
    logic pick_read;

    always_comb begin
        fifo_full  = (count_q == FullCount);
        fifo_empty = (count_q == '0);
        // A full FIFO drops the word even if the head is popped this cycle.
        push       = dl_wr && !fifo_full;
        pop        = (state_q == StWrite) && mem_req && mem_ready;

        pick_write = 1'b0;
        pick_read  = 1'b0;
        if (state_q == StIdle && !settle_q) begin
            if (!fifo_empty && rd_req) begin
                // Tie: a full FIFO forces a write, otherwise alternate types.
                if (fifo_full || !last_write_q) begin
                    pick_write = 1'b1;
                end else begin
                    pick_read = 1'b1;
                end
            end else if (!fifo_empty) begin
                pick_write = 1'b1;
            end else if (rd_req) begin
                pick_read = 1'b1;
            end
        end
    end

    assign dl_busy = fifo_full;

    // FIFO storage needs no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= dl_addr;
            fifo_data_q[wr_ptr_q] <= dl_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dl_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            if (dl_wr && fifo_full) begin
                dl_overflow <= 1'b1;
            end
        end
    end

    // Command and read-return registers are loaded on state entry so the
    // memory sees a glitch-free command that holds until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            last_write_q <= 1'b1;
            settle_q     <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            rd_ack       <= 1'b0;
            rd_data      <= '0;
        end else begin
            rd_ack <= 1'b0;
            case (state_q)
                StIdle: begin
                    settle_q <= 1'b0;
                    if (pick_write) begin
                        state_q      <= StWrite;
                        last_write_q <= 1'b1;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b1;
                        mem_addr     <= fifo_addr_q[rd_ptr_q];
                        mem_wdata    <= fifo_data_q[rd_ptr_q];
                    end else if (pick_read) begin
                        state_q      <= StRead;
                        last_write_q <= 1'b0;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= rd_addr;
                        mem_wdata    <= '0;
                    end
                end
                StWrite: begin
                    if (pop) begin
                        mem_req  <= 1'b0;
                        state_q  <= StIdle;
                        settle_q <= 1'b1;
                    end
                end
                StRead: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state_q <= StReadWait;
                    end
                end
                StReadWait: begin
                    if (mem_rvalid) begin
                        rd_data  <= mem_rdata;
                        rd_ack   <= 1'b1;
                        state_q  <= StIdle;
                        settle_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_download_mem_arbiter.sv
// tb_download_mem_arbiter: randomized and directed stimulus with a queue
// scoreboard; a negedge monitor compares every memory command, read return
// and status flag against a behavioural model of the arbiter's rules.
module tb_download_mem_arbiter;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned ADDR_WIDTH = 25;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        dl_wr;
    addr_t       dl_addr;
    logic [15:0] dl_data;
    logic        dl_busy;
    logic        dl_overflow;
    logic        rd_req;
    addr_t       rd_addr;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        mem_req;
    logic        mem_we;
    addr_t       mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    always #5 clk = ~clk;

    download_mem_arbiter #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .dl_busy    (dl_busy),
        .dl_overflow(dl_overflow),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    int n_chk = 0;
    int n_err = 0;

    // Memory model controls.
    logic [1:0] ready_mode = 2'd0;  // 0 never ready, 1 always ready, 2 random
    logic       rnd_ready  = 1'b0;
    bit         lat_rand   = 1'b0;
    int         cur_lat    = 3;
    int         last_lat   = 1;
    assign mem_ready = (ready_mode == 2'd1) || ((ready_mode == 2'd2) && rnd_ready);

    // Scoreboard / model state (owned by the monitor).
    bit                     mon_en = 1'b0;
    int                     occ = 0;
    logic [ADDR_WIDTH+15:0] exp_wr[$];
    addr_t                  exp_rd_addr[$];
    logic [15:0]            exp_rd_data[$];
    bit                     exp_ovf = 1'b0;
    bit                     rd_out = 1'b0;
    logic [15:0]            held_rd = '0;
    bit                     cmd_log[$];
    int                     wr_cnt = 0;
    int                     ack_cnt = 0;
    int                     busy_seen = 0;
    int                     cyc_n = 0;
    int                     acc_cyc = 0;
    bit                     prev_stall = 1'b0;
    bit                     prev_ack = 1'b0;
    logic [ADDR_WIDTH+17:0] prev_cmd = '0;

    function automatic logic [15:0] mem_fn(input addr_t a);
        if (a == addr_t'(32'h100)) return 16'hBEEF;
        return a[15:0] ^ 16'h3C5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        reset  = 1'b1;
        dl_wr  = 1'b0;
        rd_req = 1'b0;
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_rd_ack", 64'(rd_ack), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_dl_overflow", 64'(dl_overflow), 64'd0);
        chk("rst_dl_busy", 64'(dl_busy), 64'd0);
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic do_read(input addr_t a);
        bit got;
        got     = 1'b0;
        rd_addr = a;
        rd_req  = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            cyc(1);
            if (rd_ack) got = 1'b1;
        end
        rd_req = 1'b0;
        chk("read_done", 64'(got), 64'd1);
    endtask

    // Memory responder: one read in flight, returns mem_fn(addr) after a latency.
    initial begin : responder
        bit          acc;
        bit          pend;
        int          cnt;
        addr_t       acc_addr;
        logic [15:0] rdat;
        pend       = 1'b0;
        cnt        = 0;
        rdat       = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            acc      = mem_req && mem_ready && !mem_we && !reset;
            acc_addr = mem_addr;
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
            if (acc) begin
                pend     = 1'b1;
                cnt      = lat_rand ? int'($urandom_range(0, 3)) : cur_lat - 1;
                last_lat = cnt + 1;
                rdat     = mem_fn(acc_addr);
            end
            if (pend) begin
                if (cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdat;
                    pend       = 1'b0;
                end else begin
                    cnt--;
                end
            end
            rnd_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compares DUT outputs to the model each cycle, then folds this
    // cycle's stimulus into the model.
    initial begin : monitor
        logic [ADDR_WIDTH+15:0] e;
        logic [15:0]            d;
        addr_t                  ea;
        bit                     full_now;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (reset || !mon_en) begin
                occ = 0;
                exp_wr.delete();
                exp_rd_addr.delete();
                exp_rd_data.delete();
                exp_ovf    = 1'b0;
                rd_out     = 1'b0;
                held_rd    = '0;
                prev_stall = 1'b0;
                prev_ack   = 1'b0;
            end else begin
                full_now = (occ == FIFO_DEPTH);
                chk("dl_busy", 64'(dl_busy), 64'(full_now));
                chk("dl_overflow", 64'(dl_overflow), 64'(exp_ovf));
                if (dl_busy) busy_seen++;
                if (prev_stall) begin
                    chk("cmd_held", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'(prev_cmd));
                end
                if (rd_ack) begin
                    chk("rd_ack_pulse", 64'(prev_ack), 64'd0);
                    ack_cnt++;
                    chk("rd_ack_expected", 64'(exp_rd_data.size() != 0), 64'd1);
                    if (exp_rd_data.size() != 0) begin
                        d       = exp_rd_data.pop_front();
                        held_rd = d;
                        chk("rd_data", 64'(rd_data), 64'(d));
                        chk("rd_latency", 64'(cyc_n - acc_cyc), 64'(last_lat + 1));
                    end
                    rd_out = 1'b0;
                end else begin
                    chk("rd_data_held", 64'(rd_data), 64'(held_rd));
                end
                prev_ack = rd_ack;
                if (mem_req && mem_ready) begin
                    if (mem_we) begin
                        wr_cnt++;
                        cmd_log.push_back(1'b1);
                        chk("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
                        if (exp_wr.size() != 0) begin
                            e = exp_wr.pop_front();
                            chk("wr_addr", 64'(mem_addr), 64'(e[ADDR_WIDTH+15:16]));
                            chk("wr_data", 64'(mem_wdata), 64'(e[15:0]));
                            occ--;
                        end
                    end else begin
                        cmd_log.push_back(1'b0);
                        acc_cyc = cyc_n;
                        chk("rd_expected", 64'(exp_rd_addr.size() != 0), 64'd1);
                        if (exp_rd_addr.size() != 0) begin
                            ea = exp_rd_addr.pop_front();
                            chk("rd_addr", 64'(mem_addr), 64'(ea));
                        end
                    end
                end
                prev_stall = mem_req && !mem_ready;
                prev_cmd   = {mem_req, mem_we, mem_addr, mem_wdata};
                if (rd_req && !rd_out) begin
                    rd_out = 1'b1;
                    exp_rd_addr.push_back(rd_addr);
                    exp_rd_data.push_back(mem_fn(rd_addr));
                end
                if (dl_wr) begin
                    if (full_now) begin
                        exp_ovf = 1'b1;
                    end else begin
                        exp_wr.push_back({dl_addr, dl_data});
                        occ++;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int  w0;
        int  b0;
        int  a0;
        int  l0;
        int  l1;
        bit  seen;
        reset   = 1'b0;
        dl_wr   = 1'b0;
        dl_addr = '0;
        dl_data = '0;
        rd_req  = 1'b0;
        rd_addr = '0;
        cyc(1);
        do_reset();
        mon_en = 1'b1;

        // Four download words, memory always ready.
        ready_mode = 2'd1;
        w0 = wr_cnt;
        b0 = busy_seen;
        for (int i = 0; i < 4; i++) begin
            dl_wr   = 1'b1;
            dl_addr = addr_t'(i);
            dl_data = 16'hA000 + 16'(i);
            cyc(1);
        end
        dl_wr = 1'b0;
        cyc(20);
        chk("t1_writes", 64'(wr_cnt - w0), 64'd4);
        chk("t1_busy_never", 64'(busy_seen - b0), 64'd0);
        chk("t1_drained", 64'(exp_wr.size()), 64'd0);

        // Overflow: five back-to-back words into a stalled depth-4 FIFO.
        do_reset();
        ready_mode = 2'd0;
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            dl_wr   = 1'b1;
            dl_addr = addr_t'(32'h10 + i);
            dl_data = 16'hB000 + 16'(i);
            cyc(1);
        end
        dl_wr = 1'b0;
        chk("t2_busy", 64'(dl_busy), 64'd1);
        chk("t2_overflow", 64'(dl_overflow), 64'd1);
        ready_mode = 2'd1;
        cyc(25);
        chk("t2_writes", 64'(wr_cnt - w0), 64'd4);
        chk("t2_overflow_sticky", 64'(dl_overflow), 64'd1);

        // Single read, data returned three cycles after accept.
        do_reset();
        lat_rand = 1'b0;
        cur_lat  = 3;
        a0 = ack_cnt;
        do_read(addr_t'(32'h100));
        cyc(5);
        chk("t3_rd_data", 64'(rd_data), 64'hBEEF);
        chk("t3_acks", 64'(ack_cnt - a0), 64'd1);

        // Ties from reset: read wins first, then the types alternate.
        do_reset();
        cur_lat = 1;
        l0 = cmd_log.size();
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    dl_wr   = 1'b1;
                    dl_addr = addr_t'(32'h40 + i);
                    dl_data = 16'($urandom);
                    cyc(1);
                end
                dl_wr = 1'b0;
            end
            begin
                cyc(1);
                for (int j = 0; j < 3; j++) do_read(addr_t'(32'h80 + j));
            end
        join
        cyc(10);
        chk("t4_cmds", 64'(cmd_log.size() - l0), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (l0 + i < cmd_log.size()) chk("t4_order", 64'(cmd_log[l0+i]), 64'(i % 2));
        end

        // Full FIFO beats a pending read, even against alternation.
        do_reset();
        ready_mode = 2'd0;
        l0 = cmd_log.size();
        l1 = l0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    dl_wr   = !dl_busy;
                    dl_addr = addr_t'($urandom);
                    dl_data = 16'($urandom);
                    cyc(1);
                end
                dl_wr = 1'b0;
                l1 = cmd_log.size();
            end
            begin
                cyc(6);
                do_read(addr_t'(32'h2A));
            end
            begin
                cyc(8);
                ready_mode = 2'd1;
            end
        join
        chk("t5_writes_first", 64'(l1 - l0 >= 3), 64'd1);
        for (int i = l0; i < l1; i++) chk("t5_write_priority", 64'(cmd_log[i]), 64'd1);
        cyc(20);

        // Reset while waiting for read data; late mem_rvalid must be ignored.
        do_reset();
        cur_lat = 6;
        l0 = cmd_log.size();
        rd_addr = addr_t'(32'h33);
        rd_req  = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(1);
            if (cmd_log.size() > l0) seen = 1'b1;
        end
        chk("t6_read_accepted", 64'(seen), 64'd1);
        cyc(1);
        a0 = ack_cnt;
        do_reset();
        cyc(10);
        chk("t6_no_ack", 64'(ack_cnt - a0), 64'd0);
        chk("t6_mem_req", 64'(mem_req), 64'd0);
        chk("t6_fifo_empty", 64'(dl_busy), 64'd0);
        chk("t6_rd_data", 64'(rd_data), 64'd0);

        // Random traffic: random ready, latency, drops and read addresses.
        do_reset();
        lat_rand   = 1'b1;
        ready_mode = 2'd2;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    dl_wr   = ($urandom_range(0, 99) < 35);
                    dl_addr = addr_t'($urandom);
                    dl_data = 16'($urandom);
                    cyc(1);
                end
                dl_wr = 1'b0;
            end
            begin
                for (int j = 0; j < 25; j++) begin
                    cyc($urandom_range(0, 6));
                    do_read(addr_t'($urandom));
                end
            end
        join
        ready_mode = 2'd1;
        for (int i = 0; i < 300 && exp_wr.size() != 0; i++) cyc(1);
        cyc(5);
        chk("t7_drained", 64'(exp_wr.size()), 64'd0);
        chk("t7_no_pending_read", 64'(exp_rd_data.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
